// File: rtl/comp_pkg.sv
// Shared definitions for the wide comparator sequencer: slice width and FSM state encoding.
package comp_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/wide_comp_sequencer_if.sv
// Handshake and operand/result bundle for wide_comp_sequencer.
//   master: drives start, a, b; observes busy, done, lt, eq, gt, cmp_cycles
//   slave : the sequencer side
interface wide_comp_sequencer_if #(
  parameter int unsigned WIDTH = 16
);

  localparam int unsigned NSLICE = WIDTH / comp_pkg::SLICE_W;
  localparam int unsigned CW     = $clog2(NSLICE) + 1;

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             lt;
  logic             eq;
  logic             gt;
  logic [CW-1:0]    cmp_cycles;

  modport master (
    output start, a, b,
    input  busy, done, lt, eq, gt, cmp_cycles
  );

  modport slave (
    input  start, a, b,
    output busy, done, lt, eq, gt, cmp_cycles
  );

endinterface

// File: rtl/nibble_comp.sv
// Combinational 4-bit unsigned magnitude compare.
//   x, y : slice operands
//   lt/eq/gt : x < y, x == y, x > y (exactly one is high)
module nibble_comp (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic       lt,
  output logic       eq,
  output logic       gt
);

  assign lt = (x < y);
  assign eq = (x == y);
  assign gt = (x > y);

endmodule

// File: rtl/wide_comp_sequencer.sv
// Compares two WIDTH-bit unsigned operands one nibble per cycle, MSB nibble first,
// stopping at the first unequal slice. One shared nibble comparator does all the work.
//   clk, rst_n : clock, async active-low reset
//   bus.start  : compare request, accepted only in IDLE; bus.a/bus.b captured then
//   bus.busy   : high while not IDLE
//   bus.done   : one-cycle pulse when the result is valid
//   bus.lt/eq/gt, bus.cmp_cycles : registered result and slices examined, held until the next result
module wide_comp_sequencer
  import comp_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  wide_comp_sequencer_if.slave  bus
);

  localparam int unsigned NSLICE = WIDTH / SLICE_W;
  localparam int unsigned CW     = $clog2(NSLICE) + 1;
  localparam int unsigned IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_e           state, state_nxt;
  logic [WIDTH-1:0] a_reg, a_nxt;
  logic [WIDTH-1:0] b_reg, b_nxt;
  logic [IW-1:0]    idx, idx_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [CW-1:0]    cyc_q, cyc_nxt;
  logic             lt_q, lt_nxt;
  logic             eq_q, eq_nxt;
  logic             gt_q, gt_nxt;
  logic             busy_q;
  logic             done_q;

  logic [NSLICE-1:0][SLICE_W-1:0] a_slices;
  logic [NSLICE-1:0][SLICE_W-1:0] b_slices;
  logic [SLICE_W-1:0]             sx, sy;
  logic                           s_lt, s_eq, s_gt;

  // Slice multiplexer: view operands as nibble arrays and pick the current one
  assign a_slices = a_reg;
  assign b_slices = b_reg;
  assign sx       = a_slices[idx];
  assign sy       = b_slices[idx];

  nibble_comp u_nibble_comp (
    .x  (sx),
    .y  (sy),
    .lt (s_lt),
    .eq (s_eq),
    .gt (s_gt)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      idx    <= '0;
      cnt    <= '0;
      cyc_q  <= '0;
      lt_q   <= 1'b0;
      eq_q   <= 1'b0;
      gt_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      a_reg  <= a_nxt;
      b_reg  <= b_nxt;
      idx    <= idx_nxt;
      cnt    <= cnt_nxt;
      cyc_q  <= cyc_nxt;
      lt_q   <= lt_nxt;
      eq_q   <= eq_nxt;
      gt_q   <= gt_nxt;
      busy_q <= (state_nxt != IDLE);
      done_q <= (state_nxt == DONE);
    end
  end

  // Next-state and next-value logic; results only move on the edge entering DONE
  always_comb begin
    state_nxt = state;
    a_nxt     = a_reg;
    b_nxt     = b_reg;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    cyc_nxt   = cyc_q;
    lt_nxt    = lt_q;
    eq_nxt    = eq_q;
    gt_nxt    = gt_q;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          a_nxt     = bus.a;
          b_nxt     = bus.b;
          idx_nxt   = IW'(NSLICE - 1);
          cnt_nxt   = '0;
          state_nxt = COMPARE;
        end
      end

      COMPARE: begin
        if (!s_eq) begin
          lt_nxt    = s_lt;
          gt_nxt    = s_gt;
          eq_nxt    = 1'b0;
          cyc_nxt   = cnt + CW'(1);
          state_nxt = DONE;
        end else if (idx == '0) begin
          lt_nxt    = 1'b0;
          gt_nxt    = 1'b0;
          eq_nxt    = 1'b1;
          cyc_nxt   = CW'(NSLICE);
          state_nxt = DONE;
        end else begin
          idx_nxt = idx - IW'(1);
          cnt_nxt = cnt + CW'(1);
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.lt         = lt_q;
  assign bus.eq         = eq_q;
  assign bus.gt         = gt_q;
  assign bus.cmp_cycles = cyc_q;

endmodule

// File: tb/tb_wide_comp_sequencer.sv
// Self-checking bench for wide_comp_sequencer at WIDTH=16, 8 and 4.
module tb_wide_comp_sequencer;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wide_comp_sequencer_if #(.WIDTH(16)) bus16 ();
  wide_comp_sequencer_if #(.WIDTH(8))  bus8  ();
  wide_comp_sequencer_if #(.WIDTH(4))  bus4  ();

  wide_comp_sequencer #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  wide_comp_sequencer #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  wide_comp_sequencer #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));

  typedef struct {
    int          sel;
    logic [15:0] a;
    logic [15:0] b;
    logic        lt;
    logic        eq;
    logic        gt;
    int          cyc;
    int          lat;
  } vec_t;

  int n_pass;
  int n_total;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic drive(input int sel, input logic st, input logic [15:0] av, input logic [15:0] bv);
    case (sel)
      16: begin bus16.start = st; bus16.a = av;      bus16.b = bv;      end
      8:  begin bus8.start  = st; bus8.a  = av[7:0]; bus8.b  = bv[7:0]; end
      4:  begin bus4.start  = st; bus4.a  = av[3:0]; bus4.b  = bv[3:0]; end
      default: ;
    endcase
  endtask

  task automatic sample(input int sel, output logic d, output logic bz,
                        output logic l, output logic e, output logic g, output int c);
    d = 1'b0; bz = 1'b0; l = 1'b0; e = 1'b0; g = 1'b0; c = 0;
    case (sel)
      16: begin d = bus16.done; bz = bus16.busy; l = bus16.lt; e = bus16.eq; g = bus16.gt;
                c = int'(bus16.cmp_cycles); end
      8:  begin d = bus8.done;  bz = bus8.busy;  l = bus8.lt;  e = bus8.eq;  g = bus8.gt;
                c = int'(bus8.cmp_cycles); end
      4:  begin d = bus4.done;  bz = bus4.busy;  l = bus4.lt;  e = bus4.eq;  g = bus4.gt;
                c = int'(bus4.cmp_cycles); end
      default: ;
    endcase
  endtask

  // One start pulse, operands scrambled right after accept, then latency/result/pulse checks
  task automatic apply_vec(input vec_t v, input string tag);
    logic d, bz, l, e, g;
    int   c, lat, nbusy;
    @(negedge clk);
    drive(v.sel, 1'b1, v.a, v.b);
    @(posedge clk);
    lat = -1;
    nbusy = 0;
    d = 1'b0; bz = 1'b0; l = 1'b0; e = 1'b0; g = 1'b0; c = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) drive(v.sel, 1'b0, ~v.a, ~v.b);
      sample(v.sel, d, bz, l, e, g, c);
      if (bz) nbusy++;
      if (d) begin
        lat = k;
        break;
      end
    end
    chk({tag, " latency"}, lat, v.lat);
    chk({tag, " busy_cycles"}, nbusy, v.lat);
    chk({tag, " lt"}, int'(l), int'(v.lt));
    chk({tag, " eq"}, int'(e), int'(v.eq));
    chk({tag, " gt"}, int'(g), int'(v.gt));
    chk({tag, " cmp_cycles"}, c, v.cyc);
    chk({tag, " onehot"}, int'(l) + int'(e) + int'(g), 1);
    @(negedge clk);
    sample(v.sel, d, bz, l, e, g, c);
    chk({tag, " done_pulse_end"}, int'(d), 0);
    chk({tag, " busy_end"}, int'(bz), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[12];
    vec_t v;
    logic d, bz, l, e, g;
    int   c, lat, seen;

    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    drive(16, 1'b0, 16'h0, 16'h0);
    drive(8,  1'b0, 16'h0, 16'h0);
    drive(4,  1'b0, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    sample(16, d, bz, l, e, g, c);
    chk("reset busy", int'(bz), 0);
    chk("reset done", int'(d), 0);
    chk("reset lt", int'(l), 0);
    chk("reset eq", int'(e), 0);
    chk("reset gt", int'(g), 0);
    chk("reset cmp_cycles", c, 0);

    //            sel  a         b         lt    eq    gt    cyc lat
    tbl[0]  = '{16, 16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0, 4, 5};
    tbl[1]  = '{16, 16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1, 2};
    tbl[2]  = '{16, 16'h12A0, 16'h12B0, 1'b1, 1'b0, 1'b0, 3, 4};
    tbl[3]  = '{16, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 4, 5};
    tbl[4]  = '{16, 16'hFFFF, 16'hFFFE, 1'b0, 1'b0, 1'b1, 4, 5};
    tbl[5]  = '{16, 16'h0001, 16'h0010, 1'b1, 1'b0, 1'b0, 3, 4};
    tbl[6]  = '{16, 16'h0F00, 16'hF000, 1'b1, 1'b0, 1'b0, 1, 2};
    tbl[7]  = '{4,  16'h0007, 16'h0007, 1'b0, 1'b1, 1'b0, 1, 2};
    tbl[8]  = '{4,  16'h0003, 16'h0009, 1'b1, 1'b0, 1'b0, 1, 2};
    tbl[9]  = '{4,  16'h000F, 16'h0000, 1'b0, 1'b0, 1'b1, 1, 2};
    tbl[10] = '{8,  16'h003C, 16'h003C, 1'b0, 1'b1, 1'b0, 2, 3};
    tbl[11] = '{8,  16'h0040, 16'h003F, 1'b0, 1'b0, 1'b1, 1, 2};

    for (int i = 0; i < 12; i++) begin
      apply_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // Start held high throughout; operands change right after the first accept
    @(negedge clk);
    drive(16, 1'b1, 16'h1234, 16'h1234);
    @(posedge clk);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) drive(16, 1'b1, 16'h0000, 16'hFFFF);
      sample(16, d, bz, l, e, g, c);
      if (d) begin
        lat = k;
        break;
      end
    end
    chk("hold first latency", lat, 5);
    chk("hold first eq", int'(e), 1);
    chk("hold first lt", int'(l), 0);
    chk("hold first cmp_cycles", c, 4);
    @(negedge clk);
    sample(16, d, bz, l, e, g, c);
    chk("hold idle busy", int'(bz), 0);
    chk("hold idle done", int'(d), 0);
    @(negedge clk);
    sample(16, d, bz, l, e, g, c);
    chk("hold second busy", int'(bz), 1);
    chk("hold eq kept in compare", int'(e), 1);
    chk("hold cyc kept in compare", c, 4);
    @(negedge clk);
    sample(16, d, bz, l, e, g, c);
    drive(16, 1'b0, 16'h0, 16'h0);
    chk("hold second done", int'(d), 1);
    chk("hold second lt", int'(l), 1);
    chk("hold second eq", int'(e), 0);
    chk("hold second cmp_cycles", c, 1);
    @(negedge clk);
    sample(16, d, bz, l, e, g, c);
    chk("hold end busy", int'(bz), 0);

    // Reset in the middle of an equal compare
    @(negedge clk);
    drive(16, 1'b1, 16'h1234, 16'h1234);
    @(posedge clk);
    @(negedge clk);
    drive(16, 1'b0, 16'h0, 16'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sample(16, d, bz, l, e, g, c);
    chk("midreset busy", int'(bz), 0);
    chk("midreset done", int'(d), 0);
    chk("midreset lt", int'(l), 0);
    chk("midreset eq", int'(e), 0);
    chk("midreset gt", int'(g), 0);
    chk("midreset cmp_cycles", c, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      sample(16, d, bz, l, e, g, c);
      if (d || bz) seen++;
    end
    chk("midreset no done/busy after", seen, 0);
    v = '{16, 16'h0005, 16'h0003, 1'b0, 1'b0, 1'b1, 4, 5};
    apply_vec(v, "post_reset");

    // WIDTH=8 strided sweep against a plain magnitude reference
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 52; j++) begin
        logic [7:0] av, bv;
        av = 8'(i * 17);
        bv = 8'(j * 5);
        v.sel = 8;
        v.a   = {8'h00, av};
        v.b   = {8'h00, bv};
        v.lt  = (av < bv);
        v.eq  = (av == bv);
        v.gt  = (av > bv);
        v.cyc = (av[7:4] != bv[7:4]) ? 1 : 2;
        v.lat = v.cyc + 1;
        apply_vec(v, $sformatf("w8 %02h/%02h", av, bv));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
